// File: rtl/sensor_word_packer.sv
// Packs a sensor byte stream MSB-first into 32-bit words and writes them to a FIFO
// through a one-word hold register. Optional drop counter: define SENSOR_PACKER_DROP_CNT_EN.
module sensor_word_packer
`ifdef SENSOR_PACKER_DROP_CNT_EN
#(
  parameter int unsigned DROP_CNT_W = 8
)
`endif
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  frame_start,
  input  logic                  fifo_full,
  input  logic                  overflow_clr,
  output logic                  write_command,
  output logic [31:0]           write_data,
  output logic                  overflow,
`ifdef SENSOR_PACKER_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_count,
`endif
  output logic [1:0]            byte_lane
);

  localparam int DATA_W = 8;
  localparam int WORD_W = 32;
  localparam int PART_W = WORD_W - DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } wr_state_t;

  wr_state_t           state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          eff_lane;
  logic [PART_W-1:0]   part_q, part_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [WORD_W-1:0]   word_next;
  logic                hold_valid_q, hold_valid_d;
  logic                wr_cmd_q, wr_cmd_d;
  logic                ovf_q, ovf_d;
  logic                word_done;
  logic                word_load;
  logic                word_drop;

`ifdef SENSOR_PACKER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction
`endif

  // Byte assembly: lanes 0..2 collect into the partial word, lane 3 completes it.
  always_comb begin
    eff_lane  = frame_start ? 2'd0 : lane_q;
    lane_d    = eff_lane;
    part_d    = frame_start ? '0 : part_q;
    word_done = 1'b0;
    if (byte_valid) begin
      lane_d = eff_lane + 2'd1;
      case (eff_lane)
        2'd0:    part_d[23:16] = byte_data;
        2'd1:    part_d[15:8]  = byte_data;
        2'd2:    part_d[7:0]   = byte_data;
        default: word_done     = 1'b1;
      endcase
    end
    word_next = {part_d, byte_data};
    // The hold register is free if empty, or if its word is being written this cycle.
    word_load = word_done && (!hold_valid_q || (state_q == WRITE));
    word_drop = word_done && !word_load;
  end

  // Write FSM: IDLE waits for a held word and room, WRITE pulses, GAP forces re-sampling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_valid_q && !fifo_full) state_d = WRITE;
      WRITE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wr_cmd_d = (state_d == WRITE);
  end

  always_comb begin
    hold_d       = word_load ? word_next : hold_q;
    hold_valid_d = hold_valid_q;
    if (state_q == WRITE) hold_valid_d = 1'b0;
    if (word_load)        hold_valid_d = 1'b1;
    ovf_d = ovf_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (word_drop)    ovf_d = 1'b1;
  end

`ifdef SENSOR_PACKER_DROP_CNT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr) drop_cnt_d = '0;
    if (word_drop)    drop_cnt_d = sat_inc(overflow_clr ? '0 : drop_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_q       <= 2'd0;
      part_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      wr_cmd_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      part_q       <= part_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      wr_cmd_q     <= wr_cmd_d;
      ovf_q        <= ovf_d;
    end
  end

  assign write_command = wr_cmd_q;
  assign write_data    = hold_q;
  assign overflow      = ovf_q;
  assign byte_lane     = lane_q;

endmodule
